// File: rtl/program_loader_pkg.sv
// Shared state and error-code encodings for the program loader and its image buffer.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARM,
        ST_LOAD,
        ST_RUN,
        ST_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_HALT     = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    function automatic logic is_handshaking(input state_e s);
        return (s == ST_ARM) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/program_loader_fifo.sv
// prog_fifo: synchronous FIFO holding the RAM image between the host stream and the CPU handshake.
module prog_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = bump(wr_ptr_q);
            if (do_pop)  rd_ptr_d = bump(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: buffers a RAM image from a byte stream, then feeds it to the CPU programming handshake.
// Optional feature: define PROG_CHECKSUM_EN to require a trailing zero-sum checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int NUM_WORDS   = 16,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_resetn,
    output logic              programming,
    output logic [DATA_W-1:0] prog_data,
    input  logic              read_ui_in,
    input  logic              done_load,
    input  logic              ready,
    input  logic              HF,
    output logic              busy,
    output logic              loaded,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              restart, accept, timer_event, timed_out;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d, sum_next;
    assign sum_next = sum_q + in_data;
`endif

    assign restart     = start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERROR);
    assign fifo_flush  = reset || restart;
    assign accept      = in_valid && in_ready;
    assign fifo_pop    = (state_q == ST_LOAD) && read_ui_in && !fifo_empty;
    assign timer_event = ready || done_load;
    assign timed_out   = !timer_event && (timer_q == TW'(TIMEOUT_CYC - 1));

    // With the checksum enabled, FILL keeps accepting once the buffer is full: that byte is the sum.
`ifdef PROG_CHECKSUM_EN
    assign in_ready  = (state_q == ST_FILL);
    assign fifo_push = accept && !fifo_full;
`else
    assign in_ready  = (state_q == ST_FILL) && !fifo_full;
    assign fifo_push = accept;
`endif

    assign cpu_resetn  = is_handshaking(state_q) || (state_q == ST_RUN);
    assign programming = is_handshaking(state_q);
    assign prog_data   = (state_q == ST_LOAD) ? fifo_head : '0;
    assign busy        = (state_q == ST_FILL) || is_handshaking(state_q);
    assign loaded      = (state_q == ST_RUN);
    assign err         = (state_q == ST_ERROR);
    assign err_code    = err_code_q;

    prog_fifo #(.DEPTH(NUM_WORDS), .WIDTH(DATA_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        word_cnt_d = word_cnt_q;
        timer_d    = '0;
`ifdef PROG_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_FILL: begin
`ifdef PROG_CHECKSUM_EN
                if (fifo_push) sum_d = sum_next;
                if (accept && fifo_full) begin
                    if (sum_next == '0) begin
                        state_d = ST_ARM;
                    end else begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
`else
                if (fifo_push && fifo_count == CW'(NUM_WORDS - 1)) state_d = ST_ARM;
`endif
            end
            // Timeout outranks a halt seen in the same clock.
            ST_ARM, ST_LOAD: begin
                timer_d = timer_event ? '0 : timer_q + TW'(1);
                if (timed_out) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else if (state_q == ST_LOAD && read_ui_in && fifo_empty) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else if (HF) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_HALT;
                end else if (state_q == ST_ARM) begin
                    if (ready) state_d = ST_LOAD;
                end else if (done_load) begin
                    word_cnt_d = word_cnt_q + CW'(1);
                    if (word_cnt_q == CW'(NUM_WORDS - 1)) state_d = ST_RUN;
                end
            end
            default: ;
        endcase
        if (restart) begin
            state_d    = ST_FILL;
            err_code_d = ERR_NONE;
            word_cnt_d = '0;
`ifdef PROG_CHECKSUM_EN
            sum_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            word_cnt_q <= '0;
            timer_q    <= '0;
`ifdef PROG_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
`ifdef PROG_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: random images streamed in, a controller/RAM model drives the handshake.
module tb_program_loader;
    localparam int NUM_WORDS   = 16;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;
`ifdef PROG_CHECKSUM_EN
    localparam int NBYTES = NUM_WORDS + 1;
`else
    localparam int NBYTES = NUM_WORDS;
`endif

    typedef enum int {P_READY, P_READ, P_DONE, P_HF} pulse_e;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              read_ui_in = 1'b0;
    logic              done_load = 1'b0;
    logic              ready = 1'b0;
    logic              HF = 1'b0;
    logic              in_ready, cpu_resetn, programming, busy, loaded, err;
    logic [DATA_W-1:0] prog_data;
    logic [1:0]        err_code;

    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [7:0]  image [NUM_WORDS+1];
    logic [7:0]  ram [NUM_WORDS];
    logic [7:0]  exp_q [$];
    int          pc = 0;
    bit          mon_en = 1'b1;

    always #5 clk = ~clk;

    program_loader #(.NUM_WORDS(NUM_WORDS), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .cpu_resetn  (cpu_resetn),
        .programming (programming),
        .prog_data   (prog_data),
        .read_ui_in  (read_ui_in),
        .done_load   (done_load),
        .ready       (ready),
        .HF          (HF),
        .busy        (busy),
        .loaded      (loaded),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input pulse_e p);
        case (p)
            P_READY: ready = 1'b1;
            P_READ:  read_ui_in = 1'b1;
            P_DONE:  done_load = 1'b1;
            default: HF = 1'b1;
        endcase
        tick();
        ready = 1'b0;
        read_ui_in = 1'b0;
        done_load = 1'b0;
        HF = 1'b0;
    endtask

    // Controller/RAM model: every latched word is checked against the next expected image byte.
    always @(negedge clk) begin
        #1;
        if (read_ui_in && mon_en) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL sb_underflow: got word 0x%0h, expected none", prog_data);
            end else begin
                checkOutput("sb_word", prog_data, exp_q.pop_front());
            end
            ram[pc] = prog_data;
        end
        if (done_load) pc = (pc + 1) % NUM_WORDS;
    end

    // Image passes when all transmitted bytes sum to zero modulo 256 (always true without checksum).
    function automatic bit imageSumOk();
        int s = 0;
        for (int i = 0; i < NBYTES; i++) s += image[i];
        return (NBYTES == NUM_WORDS) || ((s % 256) == 0);
    endfunction

    task automatic genImage(input bit ones, input logic [7:0] tweak);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < NUM_WORDS; i++) begin
            image[i] = ones ? 8'h01 : 8'($urandom);
            s = s + image[i];
        end
        image[NUM_WORDS] = 8'h00 - s + tweak;
    endtask

    task automatic startLoad();
        exp_q.delete();
        pc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_cpu_reset", cpu_resetn, 0);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_err_clear", {err, err_code}, 0);
    endtask

    task automatic applyStimulus();
        int guard;
        for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back(image[i]);
        for (int i = 0; i < NBYTES; i++) begin
            while ($urandom_range(0, 2) == 0) tick();
            in_valid = 1'b1;
            in_data  = image[i];
            start    = (i == 7);
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (!in_ready) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL fill_stall: got in_ready=0 for 50 clks, expected 1");
            end
            checkOutput("fill_cpu_held", cpu_resetn, 0);
            tick();
            in_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic postFill();
        if (imageSumOk()) begin
            checkOutput("arm_in_ready", in_ready, 0);
            checkOutput("arm_outputs", {cpu_resetn, programming, busy}, 3'b111);
            in_valid = 1'b1;
            in_data = 8'hEE;
            for (int k = 0; k < 3; k++) begin
                tick();
                checkOutput("extra_byte_ready", in_ready, 0);
            end
            in_valid = 1'b0;
        end else begin
            checkOutput("csum_err", {err, err_code}, {1'b1, 2'd3});
            checkOutput("csum_cpu_held", {cpu_resetn, programming}, 0);
            repeat (3) tick();
            checkOutput("csum_cpu_still_held", cpu_resetn, 0);
        end
    endtask

    task automatic loadWords(input int first, input int last);
        for (int w = first; w <= last; w++) begin
            checkOutput("prog_high", programming, 1);
            pulse(P_READY);
            tick();
            pulse(P_READ);
            tick();
            pulse(P_DONE);
            checkOutput("prog_after_done", programming, (w == NUM_WORDS - 1) ? 0 : 1);
            tick();
        end
    endtask

    task automatic finishChecks();
        checkOutput("run_outputs", {loaded, cpu_resetn, busy, err}, 4'b1100);
        checkOutput("sb_drained", exp_q.size(), 0);
        checkOutput("pc_wrapped", pc, 0);
        for (int i = 0; i < NUM_WORDS; i++) checkOutput("ram_word", ram[i], image[i]);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        checkOutput("reset_outputs", {in_ready, cpu_resetn, programming, busy, loaded, err, err_code}, 0);
        checkOutput("reset_prog_data", prog_data, 0);

        // Normal load, then a second load restarted from RUN.
        for (int pass = 0; pass < 2; pass++) begin
            genImage(1'b0, 8'h00);
            startLoad();
            applyStimulus();
            postFill();
            loadWords(0, NUM_WORDS - 1);
            finishChecks();
        end

        // Halt flag during word 5.
        genImage(1'b0, 8'h00);
        startLoad();
        applyStimulus();
        postFill();
        loadWords(0, 4);
        pulse(P_READY);
        pulse(P_HF);
        checkOutput("hf_err", {err, err_code}, {1'b1, 2'd2});
        checkOutput("hf_outputs", {cpu_resetn, programming, busy, loaded}, 0);
        repeat (3) tick();
        checkOutput("hf_sticky", {err, err_code}, {1'b1, 2'd2});

        // done_load withheld on word 3: error lands exactly TIMEOUT_CYC clks after its ready.
        genImage(1'b0, 8'h00);
        startLoad();
        applyStimulus();
        postFill();
        loadWords(0, 2);
        pulse(P_READY);
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            read_ui_in = (k == 2);
            tick();
            if (k == TIMEOUT_CYC - 1) checkOutput("timeout_early", err, 0);
        end
        read_ui_in = 1'b0;
        checkOutput("timeout_err", {err, err_code}, {1'b1, 2'd1});
        checkOutput("timeout_cpu_held", cpu_resetn, 0);

        // read_ui_in with nothing left in the buffer.
        genImage(1'b0, 8'h00);
        startLoad();
        applyStimulus();
        postFill();
        loadWords(0, NUM_WORDS - 2);
        pulse(P_READY);
        tick();
        pulse(P_READ);
        tick();
        mon_en = 1'b0;
        pulse(P_READ);
        mon_en = 1'b1;
        checkOutput("empty_read_err", {err, err_code}, {1'b1, 2'd1});

        // Reset mid-load at word 9, junk bytes in IDLE, then a fresh image.
        genImage(1'b0, 8'h00);
        startLoad();
        applyStimulus();
        postFill();
        loadWords(0, 8);
        pulse(P_READY);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_outputs", {in_ready, cpu_resetn, programming, busy, loaded, err, err_code}, 0);
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) tick();
        in_valid = 1'b0;
        checkOutput("idle_ignores_bytes", in_ready, 0);
        genImage(1'b0, 8'h00);
        startLoad();
        applyStimulus();
        postFill();
        loadWords(0, NUM_WORDS - 1);
        finishChecks();

`ifdef PROG_CHECKSUM_EN
        genImage(1'b1, 8'h00);
        startLoad();
        applyStimulus();
        postFill();
        loadWords(0, NUM_WORDS - 1);
        finishChecks();
        genImage(1'b1, 8'h01);
        startLoad();
        applyStimulus();
        postFill();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
